bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter HOLD_MAX, default 15, meaning the maximum number of consecutive cycles one requester may own the shared databus.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port clear_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port req, input, 3 bits: bus requests; bit0 = time update, bit1 = timer set, bit2 = timer compare.
REQ-005 The module SHALL have port done, input, 3 bits: per-requester release strobe, same bit mapping as req.
REQ-006 The module SHALL have port gnt, output, 3 bits: one-hot registered grant, same bit mapping as req.
REQ-007 The module SHALL have port bus_sel, output, 2 bits: databus source select; 00 none, 01 update, 10 set, 11 compare.
REQ-008 The module SHALL have port busy, output, 1 bit: high in OWN and GAP states.
REQ-009 The module SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-010 The FSM SHALL have three states: IDLE, OWN and GAP.
REQ-011 In IDLE, when any req bit is high at edge N, the FSM SHALL enter OWN, with gnt and bus_sel valid after edge N, giving one cycle of grant latency.
REQ-012 Priority: req[0] SHALL always win.
REQ-013 Between req[1] and req[2] the arbiter SHALL use round-robin via a last-served flag; at reset the flag SHALL favour req[1].
REQ-014 The last-served flag SHALL update only when req[1] or req[2] is granted.
REQ-015 In OWN, gnt SHALL remain stable, with no preemption, even if a higher-priority req rises.
REQ-016 OWN SHALL exit to GAP on any of the following: done[owner] high, req[owner] low, or hold counter = HOLD_MAX-1 (timeout build only).
REQ-017 GAP SHALL last exactly one cycle with gnt=000 and bus_sel=00 (bus turnaround), then return to IDLE.
REQ-018 Consequence: the minimum spacing between grants is 3 cycles (OWN min 1, GAP 1, IDLE 1).
REQ-019 done bits of non-owners SHALL be ignored.
REQ-020 done in IDLE or GAP SHALL be ignored.
REQ-021 done and req from the same requester high in the same IDLE cycle SHALL grant (req wins).
REQ-022 The hold counter SHALL be ceil(log2(HOLD_MAX)) bits wide, cleared on entry to OWN, increment each OWN cycle, and saturate (no wrap).
REQ-023 gnt SHALL never have more than one bit set.
REQ-024 bus_sel SHALL always equal the encoding of gnt.

Reset
REQ-025 With clear_n low at an edge, the outputs after that edge SHALL be: gnt=000, bus_sel=00, busy=0, timeout=0, state IDLE, hold counter 0, last-served flag favouring req[1].
REQ-026 A reset during OWN SHALL drop the grant at that edge, with no GAP cycle.
REQ-027 req SHALL be ignored while clear_n is low.

Configuration
REQ-028 Macro BUS_ARBITER_TIMEOUT_EN defined: the hold counter SHALL be compiled in.
REQ-029 With BUS_ARBITER_TIMEOUT_EN defined, when the counter reaches HOLD_MAX-1 in OWN, the FSM SHALL go to GAP and timeout SHALL pulse high for the single cycle that gnt first reads 000.
REQ-030 Macro BUS_ARBITER_TIMEOUT_EN undefined: no counter SHALL be present, timeout SHALL be tied 0, and OWN SHALL exit only on done or dropped req.

Structure
REQ-031 Shared package clock_pkg SHALL hold: BUS_W=6, requester index constants (REQ_UPD=0, REQ_SET=1, REQ_CMP=2), bus_sel encodings, and the state enum arb_state_t.
REQ-032 There SHALL be one sub-module, arb_hold_timer: the hold counter plus the expiry compare, instantiated only under BUS_ARBITER_TIMEOUT_EN.
REQ-033 The priority/round-robin pick SHALL stay combinational inside bus_arbiter.

Verification
REQ-034 The bench SHALL cover: reset, then req=010 at edge 2 -> gnt=010 and bus_sel=10 after edge 2; done[1] at edge 5 -> gnt=000 after edge 5, busy low after edge 6.
REQ-035 The bench SHALL cover: req=110 held, done pulses each ownership -> grant sequence 010, 100, 010, 100 (round-robin), each separated by a GAP cycle.
REQ-036 The bench SHALL cover: owner 100 active and req[0] rises mid-OWN -> no preemption; gnt=001 is granted on the IDLE edge after GAP.
REQ-037 The bench SHALL cover (timeout build, HOLD_MAX=4): req=001 held, no done -> gnt=001 for exactly 4 cycles, then timeout=1 for one cycle with gnt=000.
REQ-038 The bench SHALL cover: clear_n low while gnt=100 -> gnt=000, bus_sel=00 and busy=0 after that edge; after release, req=110 -> gnt=010 (flag reset).
REQ-039 The bench SHALL cover: done=111 while owner is 010, with req[1] still high -> only done[1] acts; stray done bits have no effect on the next arbitration.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the timer databus arbiter: requester indices,
// bus_sel encodings and the arbiter state type.
package clock_pkg;

    localparam int BUS_W = 6;

    localparam int REQ_UPD = 0;
    localparam int REQ_SET = 1;
    localparam int REQ_CMP = 2;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_UPD  = 2'b01;
    localparam logic [1:0] SEL_SET  = 2'b10;
    localparam logic [1:0] SEL_CMP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    function automatic logic [1:0] sel_of(input logic [2:0] g);
        logic [1:0] sel;
        sel = SEL_NONE;
        if (g[REQ_UPD])
            sel = SEL_UPD;
        else if (g[REQ_SET])
            sel = SEL_SET;
        else if (g[REQ_CMP])
            sel = SEL_CMP;
        return sel;
    endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// Ownership hold counter: cleared when a grant starts, counts OWN cycles and
// flags expiry once HOLD_MAX-1 is reached. Saturates rather than wrapping.
module arb_hold_timer #(
    parameter int HOLD_MAX = 15
) (
    input  logic clk,
    input  logic clear_n,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!clear_n)
            cnt_q <= '0;
        else if (start)
            cnt_q <= '0;
        else if (run && (cnt_q != LAST))
            cnt_q <= cnt_q + 1'b1;
    end

    assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Three-requester databus arbiter (update > set/compare round-robin) with a
// one-cycle turnaround gap; forced release is built only with BUS_ARBITER_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; pick a winner from req on the next edge
// OWN     | gnt held stable until done/dropped req (or hold expiry)
// GAP     | one-cycle bus turnaround, gnt = 000, then back to IDLE
module bus_arbiter
    import clock_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [2:0] req,
    input  logic [2:0] done,
    output logic [2:0] gnt,
    output logic [1:0] bus_sel,
    output logic       busy,
    output logic       timeout
);

    arb_state_t state_q;
    logic [2:0] gnt_q;
    logic       last_cmp_q;   // 1 = compare served last, so set wins the next tie
    logic       timeout_q;
    logic [2:0] pick;
    logic       grant_start;
    logic       own_release;
    logic       expired;

    always_comb begin
        pick = 3'b000;
        if (req[REQ_UPD])
            pick[REQ_UPD] = 1'b1;
        else if (req[REQ_SET] && req[REQ_CMP]) begin
            if (last_cmp_q)
                pick[REQ_SET] = 1'b1;
            else
                pick[REQ_CMP] = 1'b1;
        end
        else if (req[REQ_SET])
            pick[REQ_SET] = 1'b1;
        else if (req[REQ_CMP])
            pick[REQ_CMP] = 1'b1;
    end

    assign grant_start = (state_q == ST_IDLE) && (|pick);
    assign own_release = (|(done & gnt_q)) || !(|(req & gnt_q)) || expired;

`ifdef BUS_ARBITER_TIMEOUT_EN
    arb_hold_timer #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_timer (
        .clk     (clk),
        .clear_n (clear_n),
        .start   (grant_start),
        .run     (state_q == ST_OWN),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 3'b000;
            last_cmp_q <= 1'b1;
            timeout_q  <= 1'b0;
        end
        else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_start) begin
                        state_q <= ST_OWN;
                        gnt_q   <= pick;
                        if (pick[REQ_SET] || pick[REQ_CMP])
                            last_cmp_q <= pick[REQ_CMP];
                    end
                end
                ST_OWN: begin
                    if (own_release) begin
                        state_q   <= ST_GAP;
                        gnt_q     <= 3'b000;
                        timeout_q <= expired;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 3'b000;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign bus_sel = sel_of(gnt_q);
    assign busy    = (state_q != ST_IDLE);
    assign timeout = timeout_q;

endmodule
